data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory stage directly downstream of RiscV_SingleCycle. Consumes the core's alu_result (address),
//  write_data and load/store controls and returns read_data. Holds a word-indexed RAM with a
//  configurable number of wait states. Asserts stall so the core freezes its pc until each access completes.
//  Supports byte, half and word loads/stores, little-endian, with misalignment detection.
// PARAMETERS
//  DEPTH        256  number of 32-bit words in the RAM (power of two)
//  WAIT_STATES  1    extra BUSY cycles per access (0..15)
// PORTS
//  clk          in   1   single clock; all state updates on its rising edge
//  reset        in   1   synchronous, active-high reset
//  mem_read     in   1   load request (from core decode)
//  mem_write    in   1   store request (from core decode)
//  funct3       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  alu_result   in   32  byte address
//  write_data   in   32  store data, right-aligned
//  read_data    out  32  load result, sign/zero-extended; valid in RESP
//  stall        out  1   1 = core must hold pc and inputs
//  misaligned   out  1   one-cycle pulse in RESP for a misaligned request
// BEHAVIOUR
//  - Reset: state=IDLE, read_data=0, misaligned=0, stall=0. RAM contents are NOT cleared.
//    Reset mid-access aborts the access. A pending store that has not reached its access cycle is dropped.
//  - FSM, three states: IDLE, BUSY, RESP.
//  - IDLE:
//    - With mem_read|mem_write=1, latch addr/data/funct3/op. Load cnt=WAIT_STATES, drive stall=1
//      combinationally, and go to BUSY.
//    - With no request, stall=0.
//  - BUSY: stall=1.
//    - If cnt!=0, decrement cnt.
//    - If cnt==0, perform the access from the latched values and go to RESP.
//  - RESP: stall=0.
//    - read_data holds the load result; the core retires the instruction this cycle. Next state is IDLE.
//    - A new request is accepted in IDLE on the following cycle, never in RESP.
//  - Latency: request cycle to RESP = WAIT_STATES+2 cycles. Back-to-back accesses cost WAIT_STATES+3 cycles each.
//  - Index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH words.
//  - Stores:
//    - SB writes byte lane addr[1:0].
//    - SH writes lanes {addr[1],0} and {addr[1],1}.
//    - SW writes all 4 lanes.
//    - Unwritten lanes keep their value.
//  - Loads:
//    - The byte/half is selected by addr[1:0].
//    - B/H sign-extend from bit 7/15; BU/HU zero-extend.
//  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): no RAM write, read_data=0, misaligned=1 in RESP.
//  - Illegal funct3 (011, 110, 111): treated as W.
//  - mem_read and mem_write both 1: treated as a store; read_data=0.
//  - read_data is updated only on entering RESP for loads. It holds its value otherwise, including through stores.
//  - Inputs changing while stall=1 are ignored, because values are latched at acceptance.
// STRUCTURE
//  - Shared package riscv_pkg holds:
//    - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//    - the FSM state encoding (ST_IDLE, ST_BUSY, ST_RESP)
//    - XLEN=32
//  - Sub-module data_mem_lane_align is combinational and holds all byte-lane logic. It produces:
//    - the write byte-enable mask and the shifted write word from addr[1:0]/funct3
//    - the extract plus sign/zero-extension of the read word
//    - the misalignment flag
//  - Top level holds the FSM, the wait counter, the request latches and the RAM array `memory`.
//    `memory` is word-indexed so benches can access it hierarchically.
// TESTING
//  1. WAIT_STATES=1. SW with addr=40, data=321 -> stall high for exactly 3 cycles.
//     memory[10]=321 at RESP, misaligned=0.
//  2. Preload memory[10]=32'h8000_00F0. Load at addr 40:
//     LB -> 32'hFFFF_FFF0; LBU -> 32'h0000_00F0; LH addr 42 -> 32'hFFFF_8000; LW -> 32'h8000_00F0.
//  3. memory[3]=32'h1122_3344, then SB addr 13, data 32'hAA -> memory[3]=32'h1122_AA44.
//     Then SH addr 14, data 32'hBEEF -> memory[3]=32'hBEEF_AA44.
//  4. LW addr 6 and SH addr 5 -> misaligned pulse 1 cycle in RESP, read_data=0, RAM unchanged.
//  5. DEPTH=256. SW addr 32'h0000_0400 + 8 -> memory[2] written (wrap).
//     Same-cycle mem_read=mem_write=1 -> store performed.
//  6. WAIT_STATES=3. Assert reset during BUSY of an SW -> next cycle IDLE, stall=0, read_data=0,
//     target word unchanged. The following LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the data-memory stage: XLEN, funct3 access sizes,
// the controller state encoding and a funct3 size decoder.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // Reserved encodings (011, 110, 111) fall through to a full-word access.
    function automatic access_size_t decode_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: decode_size = SZ_BYTE;
            F3_H, F3_HU: decode_size = SZ_HALF;
            default:     decode_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the single-cycle core (master) and the data-memory
// controller (slave).
interface data_mem_ctrl_if;
    import riscv_pkg::*;

    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] read_data;
    logic            stall;
    logic            misaligned;

    modport master (
        output mem_read, mem_write, funct3, alu_result, write_data,
        input  read_data, stall, misaligned
    );

    modport slave (
        input  mem_read, mem_write, funct3, alu_result, write_data,
        output read_data, stall, misaligned
    );

endinterface

// File: rtl/data_mem_lane_align.sv
// Combinational byte-lane steering for little-endian B/H/W accesses: write
// byte enables and lane-replicated store word, load extract/extend, misalignment.
module data_mem_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]      byte_off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] ram_word,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] write_word,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    access_size_t size;
    logic         is_unsigned;
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;

    // Store data is replicated into every lane; byte_en decides which lanes land.
    always_comb begin
        size        = decode_size(funct3);
        is_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU);
        sel_byte    = ram_word[{byte_off, 3'b000} +: 8];
        sel_half    = ram_word[{byte_off[1], 4'b0000} +: 16];
        byte_en     = 4'b0000;
        write_word  = '0;
        load_data   = '0;
        misaligned  = 1'b0;

        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << byte_off;
                write_word = {4{store_data[7:0]}};
                load_data  = is_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                misaligned = byte_off[0];
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                write_word = {2{store_data[15:0]}};
                load_data  = is_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            default: begin
                misaligned = (byte_off != 2'b00);
                byte_en    = 4'b1111;
                write_word = store_data;
                load_data  = ram_word;
            end
        endcase

        if (misaligned) begin
            byte_en   = 4'b0000;
            load_data = '0;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage behind the single-cycle core: word-indexed RAM with
// configurable wait states, stalling the core until each access completes.
module data_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0] memory [DEPTH];

    mem_state_t      state;
    mem_state_t      next_state;
    logic [3:0]      cnt;
    logic [IDX_W+1:0] addr_q;
    logic [XLEN-1:0] data_q;
    logic [2:0]      funct3_q;
    logic            is_store_q;
    logic            is_load_q;

    logic            req;
    logic            access;
    logic [IDX_W-1:0] index;
    logic [3:0]      byte_en;
    logic [XLEN-1:0] write_word;
    logic [XLEN-1:0] load_data;
    logic            mis;
    logic            unused_addr;

    assign req         = bus.mem_read | bus.mem_write;
    assign access      = (state == ST_BUSY) && (cnt == 4'd0);
    assign index       = addr_q[IDX_W+1:2];
    assign unused_addr = ^bus.alu_result[XLEN-1:IDX_W+2];

    data_mem_lane_align u_lane_align (
        .byte_off   (addr_q[1:0]),
        .funct3     (funct3_q),
        .store_data (data_q),
        .ram_word   (memory[index]),
        .byte_en    (byte_en),
        .write_word (write_word),
        .load_data  (load_data),
        .misaligned (mis)
    );

    // stall rises in the request cycle itself so the core never advances its pc.
    always_comb begin
        next_state = state;
        bus.stall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = ST_BUSY;
                    bus.stall  = 1'b1;
                end
            end
            ST_BUSY: begin
                bus.stall = 1'b1;
                if (cnt == 4'd0) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= 4'd0;
            addr_q         <= '0;
            data_q         <= '0;
            funct3_q       <= 3'b000;
            is_store_q     <= 1'b0;
            is_load_q      <= 1'b0;
            bus.read_data  <= '0;
            bus.misaligned <= 1'b0;
        end else begin
            state          <= next_state;
            bus.misaligned <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q     <= bus.alu_result[IDX_W+1:0];
                        data_q     <= bus.write_data;
                        funct3_q   <= bus.funct3;
                        is_store_q <= bus.mem_write;
                        is_load_q  <= bus.mem_read;
                        cnt        <= 4'(WAIT_STATES);
                    end
                end
                ST_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.misaligned <= mis;
                        // Plain aligned stores leave the previous load result visible.
                        if (!is_store_q) begin
                            bus.read_data <= load_data;
                        end else if (is_load_q || mis) begin
                            bus.read_data <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && access && is_store_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    memory[index][8*b +: 8] <= write_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one instance with 1 wait state, one with 3;
// drivers queue expected responses, per-instance monitors check each RESP cycle.
module tb_data_mem_ctrl;
    import riscv_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        mis;
        int          stall_cycles;
        bit          chk_mem;
        int          mem_idx;
        logic [31:0] mem_val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] model_rd [2];
    bit          prev_stall [2];
    int          stall_cnt [2];
    bit          pulse_chk [2];

    always #5 clk = ~clk;

    data_mem_ctrl_if bus1 ();
    data_mem_ctrl_if bus3 ();

    data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    data_mem_ctrl #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int sel, input int idx);
        return (sel == 0) ? dut1.memory[idx] : dut3.memory[idx];
    endfunction

    function automatic logic get_stall(input int sel);
        return (sel == 0) ? bus1.stall : bus3.stall;
    endfunction

    task automatic drive_bus(input int sel, input logic r, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus1.mem_read = r; bus1.mem_write = w; bus1.funct3 = f3;
            bus1.alu_result = a; bus1.write_data = d;
        end else begin
            bus3.mem_read = r; bus3.mem_write = w; bus3.funct3 = f3;
            bus3.alu_result = a; bus3.write_data = d;
        end
    endtask

    // Issue one access, hold it until RESP, optionally corrupting the inputs mid-access.
    task automatic apply_stimulus(input int sel, input string name, input logic rd_en, input logic wr_en,
                                  input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] exp_rd, input logic exp_mis,
                                  input int mem_idx, input logic [31:0] mem_val, input bit scramble);
        exp_t e;
        bit   done;
        e.name         = name;
        e.rd           = exp_rd;
        e.mis          = exp_mis;
        e.stall_cycles = ((sel == 0) ? 1 : 3) + 2;
        e.chk_mem      = (mem_idx >= 0);
        e.mem_idx      = mem_idx;
        e.mem_val      = mem_val;
        if (sel == 0) q1.push_back(e); else q3.push_back(e);

        @(posedge clk); #1;
        drive_bus(sel, rd_en, wr_en, f3, addr, data);
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!get_stall(sel)) begin
                done = 1;
            end else if (scramble && k == 1) begin
                #1;
                drive_bus(sel, rd_en, wr_en, f3 ^ 3'b011, ~addr, ~data);
            end
        end
        check_val({name, "_completed"}, {31'b0, done}, 32'd1);
        #1;
        drive_bus(sel, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    task automatic do_store(input int sel, input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic exp_mis, input int idx,
                            input logic [31:0] val, input bit both);
        if (both || exp_mis) model_rd[sel] = 32'd0;
        apply_stimulus(sel, name, both, 1'b1, f3, addr, data, model_rd[sel], exp_mis, idx, val, 1'b0);
    endtask

    task automatic do_load(input int sel, input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp_rd, input logic exp_mis, input bit scramble);
        model_rd[sel] = exp_rd;
        apply_stimulus(sel, name, 1'b1, 1'b0, f3, addr, 32'd0, exp_rd, exp_mis, -1, 32'd0, scramble);
    endtask

    task automatic check_output(input int sel, input exp_t e, input logic [31:0] rd, input logic mis);
        check_val({e.name, "_read_data"}, rd, e.rd);
        check_val({e.name, "_misaligned"}, {31'b0, mis}, {31'b0, e.mis});
        check_val({e.name, "_stall_cycles"}, stall_cnt[sel], e.stall_cycles);
        if (e.chk_mem) check_val({e.name, "_memory"}, mem_word(sel, e.mem_idx), e.mem_val);
    endtask

    // A falling stall edge outside reset marks the RESP cycle.
    task automatic monitor_step(input int sel);
        logic        st;
        logic        mis;
        logic [31:0] rd;
        exp_t        e;
        st  = get_stall(sel);
        mis = (sel == 0) ? bus1.misaligned : bus3.misaligned;
        rd  = (sel == 0) ? bus1.read_data : bus3.read_data;
        if (reset) begin
            prev_stall[sel] = 0;
            stall_cnt[sel]  = 0;
            pulse_chk[sel]  = 0;
        end else begin
            if (pulse_chk[sel]) begin
                check_val("misaligned_pulse_end", {31'b0, mis}, 32'd0);
                pulse_chk[sel] = 0;
            end
            if (st) begin
                stall_cnt[sel]++;
            end else if (prev_stall[sel]) begin
                if ((sel == 0 && q1.size() == 0) || (sel == 1 && q3.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: dut %0d responded, expected no response", sel);
                end else begin
                    e = (sel == 0) ? q1.pop_front() : q3.pop_front();
                    check_output(sel, e, rd, mis);
                    pulse_chk[sel] = e.mis;
                end
                stall_cnt[sel] = 0;
            end
            prev_stall[sel] = st;
        end
    endtask

    always @(negedge clk) monitor_step(0);
    always @(negedge clk) monitor_step(1);

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive_bus(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive_bus(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_stall_ws1", {31'b0, bus1.stall}, 32'd0);
        check_val("reset_rd_ws1", bus1.read_data, 32'd0);
        check_val("reset_mis_ws1", {31'b0, bus1.misaligned}, 32'd0);
        check_val("reset_stall_ws3", {31'b0, bus3.stall}, 32'd0);
        check_val("reset_rd_ws3", bus3.read_data, 32'd0);
        check_val("reset_mis_ws3", {31'b0, bus3.misaligned}, 32'd0);
        #1 reset = 1'b0;

        $display("[TB] word store and latency");
        do_store(0, "sw_40", F3_W, 32'd40, 32'd321, 1'b0, 10, 32'd321, 1'b0);

        $display("[TB] loads with sign and zero extension");
        do_store(0, "sw_40_pre", F3_W, 32'd40, 32'h8000_00F0, 1'b0, 10, 32'h8000_00F0, 1'b0);
        do_load(0, "lb_40", F3_B, 32'd40, 32'hFFFF_FFF0, 1'b0, 1'b0);
        do_load(0, "lbu_40", F3_BU, 32'd40, 32'h0000_00F0, 1'b0, 1'b0);
        do_load(0, "lh_42", F3_H, 32'd42, 32'hFFFF_8000, 1'b0, 1'b0);
        do_load(0, "lw_40_scrambled", F3_W, 32'd40, 32'h8000_00F0, 1'b0, 1'b1);
        do_load(0, "lhu_42", F3_HU, 32'd42, 32'h0000_8000, 1'b0, 1'b0);
        do_load(0, "lb_43", F3_B, 32'd43, 32'hFFFF_FF80, 1'b0, 1'b0);
        do_load(0, "l_f3_011_40", 3'b011, 32'd40, 32'h8000_00F0, 1'b0, 1'b0);

        $display("[TB] partial stores");
        do_store(0, "sw_12", F3_W, 32'd12, 32'h1122_3344, 1'b0, 3, 32'h1122_3344, 1'b0);
        do_store(0, "sb_13", F3_B, 32'd13, 32'h0000_00AA, 1'b0, 3, 32'h1122_AA44, 1'b0);
        do_store(0, "sh_14", F3_H, 32'd14, 32'h0000_BEEF, 1'b0, 3, 32'hBEEF_AA44, 1'b0);

        $display("[TB] misaligned accesses");
        do_store(0, "sw_4", F3_W, 32'd4, 32'h5555_6666, 1'b0, 1, 32'h5555_6666, 1'b0);
        do_load(0, "lw_6_mis", F3_W, 32'd6, 32'd0, 1'b1, 1'b0);
        do_load(0, "lw_4", F3_W, 32'd4, 32'h5555_6666, 1'b0, 1'b0);
        do_store(0, "sh_5_mis", F3_H, 32'd5, 32'h0000_1234, 1'b1, 1, 32'h5555_6666, 1'b0);

        $display("[TB] address wrap and read+write collision");
        do_store(0, "sw_408_wrap", F3_W, 32'h0000_0408, 32'h1357_9BDF, 1'b0, 2, 32'h1357_9BDF, 1'b0);
        do_load(0, "lw_4_again", F3_W, 32'd4, 32'h5555_6666, 1'b0, 1'b0);
        do_store(0, "rw_both_1c", F3_W, 32'h0000_001C, 32'hCAFE_F00D, 1'b0, 7, 32'hCAFE_F00D, 1'b1);

        $display("[TB] three wait states and reset mid-access");
        do_store(1, "ws3_sw_80", F3_W, 32'd80, 32'h0BAD_BEEF, 1'b0, 20, 32'h0BAD_BEEF, 1'b0);
        do_load(1, "ws3_lw_80", F3_W, 32'd80, 32'h0BAD_BEEF, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_bus(1, 1'b0, 1'b1, F3_W, 32'd80, 32'hDEAD_0000);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        drive_bus(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        check_val("ws3_abort_stall", {31'b0, bus3.stall}, 32'd0);
        check_val("ws3_abort_rd", bus3.read_data, 32'd0);
        check_val("ws3_abort_mis", {31'b0, bus3.misaligned}, 32'd0);
        check_val("ws3_abort_memory", dut3.memory[20], 32'h0BAD_BEEF);
        #1 reset = 1'b0;
        model_rd[0] = 32'd0;
        model_rd[1] = 32'd0;
        do_load(1, "ws3_lw_80_after_reset", F3_W, 32'd80, 32'h0BAD_BEEF, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_val("ws1_queue_drained", q1.size(), 32'd0);
        check_val("ws3_queue_drained", q3.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
